alu_exec_unit: RTL



---
 rtl/alu_exec_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Registered 32-bit ALU execution unit with a valid/ready request port and a 2-entry response FIFO.
// Optional feature: define ALU_SLT_EN to make op 111 a signed set-less-than.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic        rsp_ex,
    output logic        rsp_err,
    output logic [15:0] done_cnt
);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpSlt = 3'b111;

    typedef struct packed {
        logic [31:0] z;
        logic        ex;
        logic        err;
    } rsp_entry_t;

    rsp_entry_t  entry_q [2];
    rsp_entry_t  new_entry;
    rsp_entry_t  head;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, rd_ptr_q;
    logic [15:0] done_cnt_q;
    logic        accept, pop;

    // Result is computed combinationally and captured into the FIFO on accept.
    always_comb begin
        new_entry.z   = 32'h0;
        new_entry.err = 1'b0;
        case (req_op)
            OpAnd: new_entry.z = req_a & req_b;
            OpOr:  new_entry.z = req_a | req_b;
            OpAdd: new_entry.z = req_a + req_b;
            OpSub: new_entry.z = req_a - req_b;
            OpSlt: begin
`ifdef ALU_SLT_EN
                new_entry.z = ($signed(req_a) < $signed(req_b)) ? 32'h1 : 32'h0;
`else
                new_entry.z = 32'h0;
`endif
            end
            default: begin
                new_entry.z   = 32'h0;
                new_entry.err = 1'b1;
            end
        endcase
        new_entry.ex = (new_entry.z == 32'h0);
    end

    // Ready depends only on the registered count, never on rsp_ready.
    assign req_ready = (count_q != 2'd2);
    assign rsp_valid = (count_q != 2'd0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            done_cnt_q <= 16'h0;
        end else begin
            count_q <= count_d;
            if (accept) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                done_cnt_q <= done_cnt_q + 16'h1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
        end else if (accept) begin
            entry_q[wr_ptr_q] <= new_entry;
        end
    end

    assign head     = entry_q[rd_ptr_q];
    assign rsp_z    = rsp_valid ? head.z   : 32'h0;
    assign rsp_ex   = rsp_valid ? head.ex  : 1'b1;
    assign rsp_err  = rsp_valid ? head.err : 1'b0;
    assign done_cnt = done_cnt_q;

    count_in_range: assert property (@(posedge clk) disable iff (!reset_n) count_q <= 2'd2);

endmodule
